subsurf_mem_bank: RTL and testbench
===================================

// Module: subsurf_mem_bank
// PURPOSE
//  Responder side of the subsurf engine RAM interface: three single-port 2^ADDR_WIDTH x 32 RAMs
//  (bank 0 = NBR/OBJ, 1 = RES/OBJ, 2 = MAP/RES) serving en/a/we/di -> do with 1-cycle read latency.
//  Adds a host valid/ready port for loading input meshes and reading results while the engine is idle.
//  Sits between the subsurf top and the SoC host bus.
// PARAMETERS
//  ADDR_WIDTH  9  word address width per bank (depth = 2**ADDR_WIDTH)
//  DATA_WIDTH  32 word width; must be a multiple of 8 (one we bit per byte)
// PORTS
//  clk          in   1      clock, all logic rising-edge
//  rst          in   1      asynchronous reset, active-high
//  eng_busy     in   1      engine owns banks while 1 (subsurf busy)
//  en0..en2     in   1      engine port enable, per bank
//  a0..a2       in   AW     engine word address
//  we0..we2     in   4      engine byte write enables (0 = read)
//  di0..di2     in   32     engine write data
//  do0..do2     out  32     engine read data, registered
//  host_req     in   1      host access request (valid)
//  host_ready   out  1      host request accepted this cycle
//  host_sel     in   2      target bank 0..2; 3 = illegal
//  host_addr    in   AW     host word address
//  host_we      in   4      host byte write enables (0 = read)
//  host_wdata   in   32     host write data
//  host_rvalid  out  1      host read data valid (1-cycle pulse)
//  host_rdata   out  32     host read data
//  host_err     out  1      sticky: illegal sel or parity error; cleared by rst only
// BEHAVIOUR
//  Reset: do0..do2=0, host_rvalid=0, host_rdata=0, host_err=0. RAM contents not reset.
//  Ownership: eng_busy=1 -> engine port drives RAM; eng_busy=0 -> host port drives RAM, en* ignored.
//  host_ready = host_req & ~eng_busy (combinational); accept = host_req & host_ready.
//  Host held off while eng_busy=1: host must hold req/sel/addr/we/wdata stable until accepted.
//  Engine read (en=1, we=0): do<n> = mem[a] on next edge. Engine write: bytes with we[b]=1 updated,
//  do<n> holds previous value. en=0: do<n> holds.
//  Host read accept: cycle N+1 host_rvalid=1, host_rdata=mem[sel][addr]; else host_rvalid=0, rdata holds.
//  Host write accept: byte-masked write, no rvalid. Back-to-back accepts allowed, one per cycle.
//  host_sel=3 accepted: no RAM access; read -> rvalid with rdata=0; host_err set either way.
//  Write then read same address on consecutive cycles returns new data (no hazard).
//  eng_busy rising same cycle as host_req: engine wins, host_ready=0. Falling: host may accept same cycle.
//  Address beyond depth impossible by width; no wrap logic required.
//  Async rst mid-access: outputs to reset values immediately; in-flight write may or may not land.
// CONFIGURATION
//  SUBSURF_MEM_PARITY_EN defined: each bank stores 1 even-parity bit per byte, written with data;
//   any read (engine or host) with mismatch sets host_err on the cycle data is returned.
//  Not defined: no parity storage; host_err set only by illegal host_sel.
// STRUCTURE
//  subsurf_pkg: ADDR_WIDTH, DATA_WIDTH, bank index enum {BANK_NBR, BANK_RES, BANK_MAP}.
//  Sub-module subsurf_ram_bank: single-port byte-write RAM + registered dout (+ parity under macro),
//   instantiated 3x; top holds port mux, host handshake and rvalid/err regs.
// TESTING
//  eng_busy=0, host write sel=1 addr=5 we=F data=0xDEADBEEF, then read -> next cycle rvalid, rdata=0xDEADBEEF.
//  Host write we=4'b0010 data=0x0000AB00 over 0xDEADBEEF -> readback 0xDEADABEF.
//  eng_busy=1, host_req held -> host_ready=0 until eng_busy=0; engine read bank1 addr5 -> do1=0xDEADABEF next cycle.
//  Engine write bank2 addr 0x1FF we=F 0x12345678 while busy; drop busy; host read -> 0x12345678.
//  host_sel=3 read -> rvalid, rdata=0, host_err=1 sticky until rst; rst mid-read clears rvalid/err.
//  With SUBSURF_MEM_PARITY_EN: force a stored parity bit flip, read -> host_err=1; without macro err stays 0.

Source files
------------

// File: rtl/subsurf_pkg.sv
// Shared sizes and bank indices for the subsurf engine RAM banks.
package subsurf_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BANK_NBR = 2'd0,
    BANK_RES = 2'd1,
    BANK_MAP = 2'd2
  } bank_e;

  localparam logic [1:0] SEL_ILLEGAL = 2'd3;
endpackage

// File: rtl/subsurf_ram_bank.sv
// Single-port byte-write RAM with separate registered engine/host read data.
// Optional per-byte even parity under SUBSURF_MEM_PARITY_EN.
module subsurf_ram_bank
  import subsurf_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            host_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [DW-1:0]   di_i,
  output logic [DW-1:0]   eng_do_o,
  output logic [DW-1:0]   host_do_o,
  output logic            perr_o
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] eng_do_q;
  logic [DW-1:0] host_do_q;
  logic          rd_en;

  assign rd_en = en_i & ~(|we_i);

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= di_i[b*8 +: 8];
      end
    end
  end

  // Engine and host reads land in separate registers so host traffic never disturbs do<n>.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_do_q  <= '0;
      host_do_q <= '0;
    end else if (rd_en) begin
      if (host_i) host_do_q <= mem_q[addr_i];
      else        eng_do_q  <= mem_q[addr_i];
    end
  end

  assign eng_do_o  = eng_do_q;
  assign host_do_o = host_do_q;

`ifdef SUBSURF_MEM_PARITY_EN
  function automatic logic [NB-1:0] byte_par(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  logic [NB-1:0] par_q [DEPTH];
  logic          perr_q;
  logic [NB-1:0] par_new;

  assign par_new = byte_par(di_i);

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (we_i[b]) par_q[addr_i][b] <= par_new[b];
      end
    end
  end

  // Error flag is aligned with the returned read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= rd_en && (par_q[addr_i] != byte_par(mem_q[addr_i]));
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif
endmodule

// File: rtl/subsurf_mem_bank.sv
// Responder for the subsurf engine RAM interface: three banks shared between engine and host.
// Define SUBSURF_MEM_PARITY_EN to store and check per-byte parity.
module subsurf_mem_bank
  import subsurf_pkg::*;
#(
  parameter int ADDR_WIDTH = subsurf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = subsurf_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    eng_busy,
  input  logic                    en0,
  input  logic                    en1,
  input  logic                    en2,
  input  logic [ADDR_WIDTH-1:0]   a0,
  input  logic [ADDR_WIDTH-1:0]   a1,
  input  logic [ADDR_WIDTH-1:0]   a2,
  input  logic [DATA_WIDTH/8-1:0] we0,
  input  logic [DATA_WIDTH/8-1:0] we1,
  input  logic [DATA_WIDTH/8-1:0] we2,
  input  logic [DATA_WIDTH-1:0]   di0,
  input  logic [DATA_WIDTH-1:0]   di1,
  input  logic [DATA_WIDTH-1:0]   di2,
  output logic [DATA_WIDTH-1:0]   do0,
  output logic [DATA_WIDTH-1:0]   do1,
  output logic [DATA_WIDTH-1:0]   do2,
  input  logic                    host_req,
  output logic                    host_ready,
  input  logic [1:0]              host_sel,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [DATA_WIDTH/8-1:0] host_we,
  input  logic [DATA_WIDTH-1:0]   host_wdata,
  output logic                    host_rvalid,
  output logic [DATA_WIDTH-1:0]   host_rdata,
  output logic                    host_err
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int NB = DW / 8;

  logic          accept;
  logic          host_rd;
  logic [2:0]    eng_en;
  logic [AW-1:0] eng_a  [3];
  logic [NB-1:0] eng_we [3];
  logic [DW-1:0] eng_di [3];
  logic [2:0]    b_en;
  logic [AW-1:0] b_addr [3];
  logic [NB-1:0] b_we   [3];
  logic [DW-1:0] b_di   [3];
  logic [DW-1:0] host_do [3];
  logic [2:0]    perr;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rsel_q, rsel_d;
  logic          err_q, err_d;

  assign host_ready = host_req & ~eng_busy;
  assign accept     = host_req & host_ready;
  assign host_rd    = accept & ~(|host_we);

  assign eng_en    = {en2, en1, en0};
  assign eng_a[0]  = a0;
  assign eng_a[1]  = a1;
  assign eng_a[2]  = a2;
  assign eng_we[0] = we0;
  assign eng_we[1] = we1;
  assign eng_we[2] = we2;
  assign eng_di[0] = di0;
  assign eng_di[1] = di1;
  assign eng_di[2] = di2;

  // Ownership mux: the engine has the banks while busy, otherwise the accepted host request.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      b_en[n]   = 1'b0;
      b_addr[n] = host_addr;
      b_we[n]   = host_we;
      b_di[n]   = host_wdata;
      if (eng_busy) begin
        b_en[n]   = eng_en[n];
        b_addr[n] = eng_a[n];
        b_we[n]   = eng_we[n];
        b_di[n]   = eng_di[n];
      end else begin
        b_en[n] = accept && (host_sel == n[1:0]);
      end
    end
  end

  subsurf_ram_bank #(.AW(AW), .DW(DW)) u_bank0 (
    .clk(clk), .rst(rst), .en_i(b_en[0]), .host_i(~eng_busy), .addr_i(b_addr[0]),
    .we_i(b_we[0]), .di_i(b_di[0]), .eng_do_o(do0), .host_do_o(host_do[0]), .perr_o(perr[0])
  );
  subsurf_ram_bank #(.AW(AW), .DW(DW)) u_bank1 (
    .clk(clk), .rst(rst), .en_i(b_en[1]), .host_i(~eng_busy), .addr_i(b_addr[1]),
    .we_i(b_we[1]), .di_i(b_di[1]), .eng_do_o(do1), .host_do_o(host_do[1]), .perr_o(perr[1])
  );
  subsurf_ram_bank #(.AW(AW), .DW(DW)) u_bank2 (
    .clk(clk), .rst(rst), .en_i(b_en[2]), .host_i(~eng_busy), .addr_i(b_addr[2]),
    .we_i(b_we[2]), .di_i(b_di[2]), .eng_do_o(do2), .host_do_o(host_do[2]), .perr_o(perr[2])
  );

  always_comb begin
    rvalid_d = host_rd;
    rsel_d   = host_rd ? host_sel : rsel_q;
    err_d    = err_q | (|perr) | (accept && (host_sel == SEL_ILLEGAL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rsel_q   <= SEL_ILLEGAL;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rsel_q   <= rsel_d;
      err_q    <= err_d;
    end
  end

  // rsel_q remembers which bank answered the last host read; illegal or none returns zero.
  always_comb begin
    host_rdata = '0;
    case (rsel_q)
      BANK_NBR: host_rdata = host_do[0];
      BANK_RES: host_rdata = host_do[1];
      BANK_MAP: host_rdata = host_do[2];
      default:  host_rdata = '0;
    endcase
  end

  assign host_rvalid = rvalid_q;
  assign host_err    = err_q | (|perr);
endmodule

// File: tb/tb_subsurf_mem_bank.sv
// Self-checking bench for subsurf_mem_bank: vector table, directed corner sequences, randomized model check.
module tb_subsurf_mem_bank;
  logic        clk = 1'b0;
  logic        rst, eng_busy;
  logic        en0, en1, en2;
  logic [8:0]  a0, a1, a2;
  logic [3:0]  we0, we1, we2;
  logic [31:0] di0, di1, di2;
  logic [31:0] do0, do1, do2;
  logic        host_req, host_ready, host_rvalid, host_err;
  logic [1:0]  host_sel;
  logic [8:0]  host_addr;
  logic [3:0]  host_we;
  logic [31:0] host_wdata, host_rdata;

  int checks = 0;
  int errors = 0;

`ifdef SUBSURF_MEM_PARITY_EN
  localparam logic PAR_ERR_EXP = 1'b1;
`else
  localparam logic PAR_ERR_EXP = 1'b0;
`endif

  subsurf_mem_bank dut (
    .clk(clk), .rst(rst), .eng_busy(eng_busy),
    .en0(en0), .en1(en1), .en2(en2), .a0(a0), .a1(a1), .a2(a2),
    .we0(we0), .we1(we1), .we2(we2), .di0(di0), .di1(di1), .di2(di2),
    .do0(do0), .do1(do1), .do2(do2),
    .host_req(host_req), .host_ready(host_ready), .host_sel(host_sel),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    eng_busy = 0; en0 = 0; en1 = 0; en2 = 0;
    a0 = '0; a1 = '0; a2 = '0; we0 = '0; we1 = '0; we2 = '0;
    di0 = '0; di1 = '0; di2 = '0;
    host_req = 0; host_sel = '0; host_addr = '0; host_we = '0; host_wdata = '0;
  endtask

  task automatic host_drive(input logic [1:0] sel, input logic [8:0] addr, input logic [3:0] we, input logic [31:0] wd);
    host_req = 1; host_sel = sel; host_addr = addr; host_we = we; host_wdata = wd;
  endtask

  typedef struct {
    logic        busy;
    logic        req;
    logic [1:0]  sel;
    logic [8:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  // Reference model state for the randomized phase
  logic [31:0] mdl [3][16];
  logic [31:0] exp_do [3];
  logic        exp_rv, exp_err;
  logic [31:0] exp_rdata;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 2'd1, 9'd5,     4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 9'd5,     4'h0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b1, 2'd1, 9'd5,     4'h2, 32'h0000AB00, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 9'd5,     4'h0, 32'h0,        1'b1, 1'b1, 32'hDEADABEF};
    tbl[4] = '{1'b1, 1'b1, 2'd1, 9'd5,     4'h0, 32'h0,        1'b0, 1'b0, 32'hDEADABEF};
    tbl[5] = '{1'b0, 1'b0, 2'd1, 9'd5,     4'h0, 32'h0,        1'b0, 1'b0, 32'hDEADABEF};
    tbl[6] = '{1'b0, 1'b1, 2'd0, 9'd7,     4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'hDEADABEF};
    tbl[7] = '{1'b0, 1'b1, 2'd0, 9'd7,     4'h0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D};
    tbl[8] = '{1'b0, 1'b1, 2'd2, 9'h1FF,   4'hF, 32'h0BADC0DE, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[9] = '{1'b0, 1'b1, 2'd2, 9'h1FF,   4'h0, 32'h0,        1'b1, 1'b1, 32'h0BADC0DE};

    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset do0", do0, 32'h0);
    chk("reset do1", do1, 32'h0);
    chk("reset do2", do2, 32'h0);
    chk("reset rvalid", {31'h0, host_rvalid}, 32'h0);
    chk("reset rdata", host_rdata, 32'h0);
    chk("reset err", {31'h0, host_err}, 32'h0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      eng_busy = tbl[i].busy;
      host_req = tbl[i].req; host_sel = tbl[i].sel; host_addr = tbl[i].addr;
      host_we = tbl[i].we; host_wdata = tbl[i].wdata;
      #1;
      chk($sformatf("vec%0d ready", i), {31'h0, host_ready}, {31'h0, tbl[i].exp_ready});
      @(negedge clk);
      chk($sformatf("vec%0d rvalid", i), {31'h0, host_rvalid}, {31'h0, tbl[i].exp_rv});
      chk($sformatf("vec%0d rdata", i), host_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'h0, host_err}, 32'h0);
    end
    chk("host traffic leaves do1", do1, 32'h0);

    // Engine ownership: host held off, engine read and write
    eng_busy = 1; host_drive(2'd1, 9'd5, 4'h0, 32'h0);
    en1 = 1; a1 = 9'd5; we1 = 4'h0;
    #1 chk("busy ready", {31'h0, host_ready}, 32'h0);
    @(negedge clk);
    chk("eng read do1", do1, 32'hDEADABEF);
    chk("busy no rvalid", {31'h0, host_rvalid}, 32'h0);
    en1 = 0; en2 = 1; a2 = 9'h1FF; we2 = 4'hF; di2 = 32'h12345678;
    #1 chk("busy ready held", {31'h0, host_ready}, 32'h0);
    @(negedge clk);
    chk("eng write holds do2", do2, 32'h0);
    chk("do1 holds", do1, 32'hDEADABEF);
    eng_busy = 0; host_drive(2'd2, 9'h1FF, 4'h0, 32'h0);
    #1 chk("busy fall ready", {31'h0, host_ready}, 32'h1);
    @(negedge clk);
    chk("eng write rvalid", {31'h0, host_rvalid}, 32'h1);
    chk("eng write readback", host_rdata, 32'h12345678);
    idle_inputs();

    // Parity: corrupt one stored parity bit, then read it back
`ifdef SUBSURF_MEM_PARITY_EN
    dut.u_bank1.par_q[5] = dut.u_bank1.par_q[5] ^ 4'b0001;
`endif
    host_drive(2'd1, 9'd5, 4'h0, 32'h0);
    @(negedge clk);
    chk("parity rvalid", {31'h0, host_rvalid}, 32'h1);
    chk("parity rdata", host_rdata, 32'hDEADABEF);
    chk("parity err", {31'h0, host_err}, {31'h0, PAR_ERR_EXP});
    host_req = 0;

    // Illegal select: read returns zero and sets sticky error
    host_drive(2'd3, 9'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("sel3 rvalid", {31'h0, host_rvalid}, 32'h1);
    chk("sel3 rdata", host_rdata, 32'h0);
    chk("sel3 err", {31'h0, host_err}, 32'h1);
    host_drive(2'd3, 9'd0, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    chk("sel3 write rvalid", {31'h0, host_rvalid}, 32'h0);
    host_req = 0;
    @(negedge clk);
    chk("err sticky", {31'h0, host_err}, 32'h1);
    chk("sel3 rdata holds", host_rdata, 32'h0);
    host_drive(2'd1, 9'd5, 4'h0, 32'h0);
    @(negedge clk);
    chk("pre-rst rvalid", {31'h0, host_rvalid}, 32'h1);
    chk("pre-rst rdata", host_rdata, 32'hDEADABEF);
    host_req = 0;
    rst = 1;
    #1;
    chk("async rst rvalid", {31'h0, host_rvalid}, 32'h0);
    chk("async rst err", {31'h0, host_err}, 32'h0);
    chk("async rst rdata", host_rdata, 32'h0);
    chk("async rst do1", do1, 32'h0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Randomized phase: preload a small window of every bank through the host
    for (int b = 0; b < 3; b++) begin
      for (int ad = 0; ad < 16; ad++) begin
        mdl[b][ad] = $urandom;
        host_drive(b[1:0], ad[8:0], 4'hF, mdl[b][ad]);
        @(negedge clk);
      end
    end
    host_req = 0;
    for (int b = 0; b < 3; b++) exp_do[b] = 32'h0;
    exp_rv = 0; exp_rdata = 32'h0; exp_err = 0;
    @(negedge clk);

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] ens;
      logic [3:0] wes [3];
      logic [8:0] as [3];
      logic [31:0] ds [3];
      chk("rnd do0", do0, exp_do[0]);
      chk("rnd do1", do1, exp_do[1]);
      chk("rnd do2", do2, exp_do[2]);
      chk("rnd rvalid", {31'h0, host_rvalid}, {31'h0, exp_rv});
      chk("rnd rdata", host_rdata, exp_rdata);
      chk("rnd err", {31'h0, host_err}, {31'h0, exp_err});

      eng_busy = ($urandom_range(0, 2) == 0);
      ens = 4'($urandom);
      for (int b = 0; b < 3; b++) begin
        wes[b] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        as[b]  = 9'($urandom_range(0, 15));
        ds[b]  = $urandom;
      end
      en0 = ens[0]; en1 = ens[1]; en2 = ens[2];
      a0 = as[0]; a1 = as[1]; a2 = as[2];
      we0 = wes[0]; we1 = wes[1]; we2 = wes[2];
      di0 = ds[0]; di1 = ds[1]; di2 = ds[2];
      host_req = ($urandom_range(0, 3) != 0);
      host_sel = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      host_addr = 9'($urandom_range(0, 15));
      host_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      host_wdata = $urandom;
      #1;
      chk("rnd ready", {31'h0, host_ready}, {31'h0, host_req & ~eng_busy});

      exp_rv = 0;
      if (eng_busy) begin
        for (int b = 0; b < 3; b++) begin
          if (ens[b]) begin
            if (wes[b] == 4'h0) exp_do[b] = mdl[b][as[b][3:0]];
            else mdl[b][as[b][3:0]] = merge(mdl[b][as[b][3:0]], ds[b], wes[b]);
          end
        end
      end else if (host_req) begin
        if (host_sel == 2'd3) begin
          exp_err = 1;
          if (host_we == 4'h0) begin exp_rv = 1; exp_rdata = 32'h0; end
        end else if (host_we == 4'h0) begin
          exp_rv = 1;
          exp_rdata = mdl[host_sel][host_addr[3:0]];
        end else begin
          mdl[host_sel][host_addr[3:0]] = merge(mdl[host_sel][host_addr[3:0]], host_wdata, host_we);
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
